alu_arbiter_ctrl: RTL and testbench

ALU_ARBITER_CTRL -- requirements
Module: alu_arbiter_ctrl

---
 rtl/alu_arbiter_ctrl.sv | 169 ++++++++++++++++
 tb/tb_alu_arbiter_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_ctrl.sv
// Two-requester round-robin front end for a registered 4-bit ALU.
// Sequences operand load, execute wait, result write, capture and response handshake.
module alu_arbiter_ctrl #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] m0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic [3:0] m1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       alu_read,
  output logic       alu_write,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_m,
  input  logic [3:0] alu_r,
  input  logic       alu_s,
  input  logic       alu_z,
  input  logic       alu_o,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_r,
  output logic [2:0] rsp_flags,
  output logic       busy,
  output logic [7:0] ops_done
);

  localparam int unsigned DW    = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned OPS_W = 8;
  localparam int unsigned FLG_W = 3;

  typedef enum logic [2:0] {IDLE, LOAD, EXEC, WRITE, CAPT, RESP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [DW-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_m_q, alu_m_d;
  logic             alu_read_q, alu_read_d, alu_write_q, alu_write_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic [DW-1:0]    rsp_r_q, rsp_r_d;
  logic [FLG_W-1:0] rsp_flags_q, rsp_flags_d;
  logic             busy_q, busy_d;
  logic [OPS_W-1:0] ops_q, ops_d;
  logic             grant_any, grant_id;

  // Next state; the grant is decoded in the IDLE cycle itself so operands are taken that cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    id_d        = id_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_m_d     = alu_m_q;
    rsp_id_d    = rsp_id_q;
    rsp_r_d     = rsp_r_q;
    rsp_flags_d = rsp_flags_q;
    ops_d       = ops_q;
    grant_any   = 1'b0;
    grant_id    = 1'b0;
    gnt0        = 1'b0;
    gnt1        = 1'b0;

    case (state_q)
      IDLE: begin
        if ((req0 || req1) && !Reset) begin
          grant_any = 1'b1;
          // last_q holds the requester served last; the other one wins a tie
          grant_id  = req1 && (!req0 || !last_q);
          gnt0      = !grant_id;
          gnt1      = grant_id;
          id_d      = grant_id;
          last_d    = grant_id;
          alu_a_d   = grant_id ? a1 : a0;
          alu_b_d   = grant_id ? b1 : b0;
          alu_m_d   = grant_id ? m1 : m0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = CNT_W'(EXEC_CYCLES - 1);
        state_d = EXEC;
      end
      EXEC: begin
        if (cnt_q == '0) state_d = WRITE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      WRITE: state_d = CAPT;
      CAPT: begin
        rsp_r_d     = alu_r;
        rsp_flags_d = {alu_s, alu_z, alu_o};
        rsp_id_d    = id_q;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          ops_d   = ops_q + OPS_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    alu_read_d  = (state_d == LOAD);
    alu_write_d = (state_d == WRITE);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  // Reset abandons any in-flight operation and restores requester 0 priority.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_m_q     <= '0;
      alu_read_q  <= 1'b0;
      alu_write_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_r_q     <= '0;
      rsp_flags_q <= '0;
      busy_q      <= 1'b0;
      ops_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      id_q        <= id_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_m_q     <= alu_m_d;
      alu_read_q  <= alu_read_d;
      alu_write_q <= alu_write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_r_q     <= rsp_r_d;
      rsp_flags_q <= rsp_flags_d;
      busy_q      <= busy_d;
      ops_q       <= ops_d;
    end
  end

  assign alu_read  = alu_read_q;
  assign alu_write = alu_write_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_m     = alu_m_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_flags = rsp_flags_q;
  assign busy      = busy_q;
  assign ops_done  = ops_q;

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Bench for alu_arbiter_ctrl: instance 0 with EXEC_CYCLES=1, instance 1 with EXEC_CYCLES=4.
// Stub ALU result register loads (a + b - m) on alu_write; flags come from stub_flags.
module tb_alu_arbiter_ctrl;

  typedef struct packed {
    logic       id;
    logic [3:0] r;
    logic [2:0] f;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rsp_ready;
  logic [3:0] a0, b0, m0, a1, b1, m1;
  logic [2:0] stub_flags;

  logic       req0_i [2];
  logic       req1_i [2];
  logic [3:0] alu_r_i [2];
  logic       s_i [2], z_i [2], o_i [2];
  logic       gnt0_o [2], gnt1_o [2], rd_o [2], wr_o [2];
  logic [3:0] alu_a_o [2], alu_b_o [2], alu_m_o [2];
  logic       rv_o [2], rid_o [2], busy_o [2];
  logic [3:0] rr_o [2];
  logic [2:0] rf_o [2];
  logic [7:0] ops_o [2];

  exp_t sb0[$];
  exp_t sb1[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_ops [2];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    alu_arbiter_ctrl #(.EXEC_CYCLES((i == 0) ? 1 : 4)) u_dut (
      .Clk(clk), .Reset(reset),
      .req0(req0_i[i]), .req1(req1_i[i]),
      .a0(a0), .b0(b0), .m0(m0), .a1(a1), .b1(b1), .m1(m1),
      .gnt0(gnt0_o[i]), .gnt1(gnt1_o[i]),
      .alu_read(rd_o[i]), .alu_write(wr_o[i]),
      .alu_a(alu_a_o[i]), .alu_b(alu_b_o[i]), .alu_m(alu_m_o[i]),
      .alu_r(alu_r_i[i]), .alu_s(s_i[i]), .alu_z(z_i[i]), .alu_o(o_i[i]),
      .rsp_valid(rv_o[i]), .rsp_ready(rsp_ready),
      .rsp_id(rid_o[i]), .rsp_r(rr_o[i]), .rsp_flags(rf_o[i]),
      .busy(busy_o[i]), .ops_done(ops_o[i])
    );
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        alu_r_i[i] <= 4'h0; s_i[i] <= 1'b0; z_i[i] <= 1'b0; o_i[i] <= 1'b0;
      end else if (wr_o[i]) begin
        alu_r_i[i] <= alu_a_o[i] + alu_b_o[i] - alu_m_o[i];
        {s_i[i], z_i[i], o_i[i]} <= stub_flags;
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic void push_exp(input int inst, input logic id, input logic [3:0] r,
                                   input logic [2:0] f);
    exp_t e;
    e.id = id; e.r = r; e.f = f;
    if (inst == 0) sb0.push_back(e);
    else           sb1.push_back(e);
  endfunction

  // Scoreboard monitor plus per-cycle invariants.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("inv_gnt_both_%0d", i), int'(gnt0_o[i] & gnt1_o[i]), 0);
      chk($sformatf("inv_rd_wr_%0d", i), int'(rd_o[i] & wr_o[i]), 0);
      chk($sformatf("inv_gnt_busy_%0d", i), int'((gnt0_o[i] | gnt1_o[i]) & busy_o[i]), 0);
      if (rv_o[i] && rsp_ready && !reset) begin
        if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
          chk($sformatf("sb_unexpected_rsp_%0d", i), 1, 0);
        end else begin
          e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
          chk($sformatf("sb_id_%0d", i), int'(rid_o[i]), int'(e.id));
          chk($sformatf("sb_r_%0d", i), int'(rr_o[i]), int'(e.r));
          chk($sformatf("sb_flags_%0d", i), int'(rf_o[i]), int'(e.f));
        end
      end
    end
  end

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_ops[0] = 0; exp_ops[1] = 0;
  endtask

  // One uncontended operation with cycle-exact timing checks relative to the grant cycle.
  task automatic run_op(input int inst, input logic id, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] m, input logic [2:0] fl, input logic [3:0] er);
    int e_c;
    e_c = (inst == 0) ? 1 : 4;
    @(posedge clk); #1;
    if (id) begin a1 = a; b1 = b; m1 = m; req1_i[inst] = 1'b1; end
    else    begin a0 = a; b0 = b; m0 = m; req0_i[inst] = 1'b1; end
    stub_flags = fl; rsp_ready = 1'b1;
    push_exp(inst, id, er, fl);
    for (int k = 0; k <= 4 + e_c; k++) begin
      @(negedge clk);
      chk($sformatf("op%0d_gnt_k%0d", inst, k), int'(id ? gnt1_o[inst] : gnt0_o[inst]), int'(k == 0));
      chk($sformatf("op%0d_read_k%0d", inst, k), int'(rd_o[inst]), int'(k == 1));
      chk($sformatf("op%0d_write_k%0d", inst, k), int'(wr_o[inst]), int'(k == 2 + e_c));
      chk($sformatf("op%0d_valid_k%0d", inst, k), int'(rv_o[inst]), int'(k == 4 + e_c));
      if (k == 1) begin
        chk("op_alu_a", int'(alu_a_o[inst]), int'(a));
        chk("op_alu_b", int'(alu_b_o[inst]), int'(b));
        chk("op_alu_m", int'(alu_m_o[inst]), int'(m));
      end
      if (k == 0) begin
        @(posedge clk); #1;
        req0_i[inst] = 1'b0; req1_i[inst] = 1'b0;
      end
    end
    exp_ops[inst]++;
    @(negedge clk);
    chk($sformatf("op%0d_ops_done", inst), int'(ops_o[inst]), exp_ops[inst]);
    chk($sformatf("op%0d_busy_after", inst), int'(busy_o[inst]), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ng;
    bit  seen;
    bit  seq [4];
    bit  exp_seq [4];
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
    reset = 1'b1; rsp_ready = 1'b1; stub_flags = 3'b000;
    a0 = 4'h9; b0 = 4'h9; m0 = 4'h9; a1 = 4'h0; b1 = 4'h0; m1 = 4'h0;
    for (int i = 0; i < 2; i++) begin req0_i[i] = 1'b1; req1_i[i] = 1'b0; exp_ops[i] = 0; end

    // Reset with requests and rsp_ready high: reset dominates, all outputs at reset values
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_gnt0", int'(gnt0_o[i]), 0);
      chk("rst_gnt1", int'(gnt1_o[i]), 0);
      chk("rst_read", int'(rd_o[i]), 0);
      chk("rst_write", int'(wr_o[i]), 0);
      chk("rst_alu_a", int'(alu_a_o[i]), 0);
      chk("rst_alu_b", int'(alu_b_o[i]), 0);
      chk("rst_alu_m", int'(alu_m_o[i]), 0);
      chk("rst_valid", int'(rv_o[i]), 0);
      chk("rst_id", int'(rid_o[i]), 0);
      chk("rst_r", int'(rr_o[i]), 0);
      chk("rst_flags", int'(rf_o[i]), 0);
      chk("rst_busy", int'(busy_o[i]), 0);
      chk("rst_ops", int'(ops_o[i]), 0);
    end
    @(posedge clk); #1;
    reset = 1'b0; req0_i[0] = 1'b0; req0_i[1] = 1'b0;

    // Reset pulsed during EXEC discards the operation
    @(posedge clk); #1;
    a0 = 4'h3; b0 = 4'h5; m0 = 4'h2; req0_i[0] = 1'b1;
    @(negedge clk);
    chk("rexec_gnt0", int'(gnt0_o[0]), 1);
    @(posedge clk); #1 req0_i[0] = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rexec_read", int'(rd_o[0]), 0);
    chk("rexec_write", int'(wr_o[0]), 0);
    chk("rexec_busy", int'(busy_o[0]), 0);
    chk("rexec_alu_a", int'(alu_a_o[0]), 0);
    chk("rexec_alu_m", int'(alu_m_o[0]), 0);
    chk("rexec_r", int'(rr_o[0]), 0);
    chk("rexec_ops", int'(ops_o[0]), 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rv_o[0] || wr_o[0]) seen = 1'b1;
    end
    chk("rexec_no_rsp", int'(seen), 0);

    // Single request, EXEC_CYCLES=1: 3+5-2 = 6, flags 000
    run_op(0, 1'b0, 4'h3, 4'h5, 4'h2, 3'b000, 4'h6);
    // EXEC_CYCLES=4 on requester 1: 2+2-0 = 4, flags S=1 Z=1 O=0
    run_op(1, 1'b1, 4'h2, 4'h2, 4'h0, 3'b110, 4'h4);

    // Contention: both held after reset, grants alternate starting with 0
    pulse_reset();
    a0 = 4'h1; b0 = 4'h2; m0 = 4'h0; a1 = 4'h7; b1 = 4'h4; m1 = 4'h1;
    stub_flags = 3'b000; rsp_ready = 1'b1;
    push_exp(0, 1'b0, 4'h3, 3'b000); push_exp(0, 1'b1, 4'hA, 3'b000);
    push_exp(0, 1'b0, 4'h3, 3'b000); push_exp(0, 1'b1, 4'hA, 3'b000);
    req0_i[0] = 1'b1; req1_i[0] = 1'b1;
    ng = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (gnt0_o[0] || gnt1_o[0]) begin
        seq[ng] = gnt1_o[0];
        ng++;
        if (ng == 4) begin
          @(posedge clk); #1;
          req0_i[0] = 1'b0; req1_i[0] = 1'b0;
          break;
        end
      end
    end
    chk("cont_grant_count", ng, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("cont_order_%0d", i), int'(seq[i]), int'(exp_seq[i]));
    req0_i[0] = 1'b0; req1_i[0] = 1'b0;
    repeat (10) @(negedge clk);
    exp_ops[0] += 4;
    chk("cont_ops", int'(ops_o[0]), exp_ops[0]);

    // Back-pressure: response held for 10 cycles, pending req1 not granted
    @(posedge clk); #1;
    a0 = 4'hF; b0 = 4'hF; m0 = 4'h3; rsp_ready = 1'b0; req0_i[0] = 1'b1;
    push_exp(0, 1'b0, 4'hB, 3'b000);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = gnt0_o[0];
    end
    chk("bp_grant_seen", int'(seen), 1);
    @(posedge clk); #1;
    req0_i[0] = 1'b0; req1_i[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = rv_o[0];
    end
    chk("bp_valid_seen", int'(seen), 1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_valid_hold", int'(rv_o[0]), 1);
      chk("bp_r_hold", int'(rr_o[0]), 11);
      chk("bp_id_hold", int'(rid_o[0]), 0);
      chk("bp_busy", int'(busy_o[0]), 1);
      chk("bp_no_grant", int'(gnt0_o[0] | gnt1_o[0]), 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    push_exp(0, 1'b1, 4'hA, 3'b000);
    @(negedge clk);
    chk("bp_handshake_valid", int'(rv_o[0]), 1);
    @(negedge clk);
    chk("bp_idle_busy", int'(busy_o[0]), 0);
    chk("bp_next_gnt1", int'(gnt1_o[0]), 1);
    @(posedge clk); #1 req1_i[0] = 1'b0;
    repeat (10) @(negedge clk);
    exp_ops[0] += 2;
    chk("bp_ops", int'(ops_o[0]), exp_ops[0]);

    // Wrap: 256 completions bring ops_done back to 0
    pulse_reset();
    a0 = 4'h1; b0 = 4'h1; m0 = 4'h0; rsp_ready = 1'b1; stub_flags = 3'b000;
    for (int i = 0; i < 256; i++) push_exp(0, 1'b0, 4'h2, 3'b000);
    req0_i[0] = 1'b1;
    ng = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (gnt0_o[0]) begin
        ng++;
        if (ng == 256) begin
          chk("wrap_ops_255", int'(ops_o[0]), 255);
          @(posedge clk); #1 req0_i[0] = 1'b0;
          break;
        end
      end
    end
    req0_i[0] = 1'b0;
    chk("wrap_grant_count", ng, 256);
    repeat (10) @(negedge clk);
    chk("wrap_ops_zero", int'(ops_o[0]), 0);
    chk("wrap_busy", int'(busy_o[0]), 0);

    chk("sb0_empty", sb0.size(), 0);
    chk("sb1_empty", sb1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
